fetch_stage: RTL and testbench

- Instruction-fetch front end of the LC-3b pipeline: owns the PC and issues word reads to instruction memory over the mem_read/mem_resp protocol.
- Holds one fetched instruction in an IF/ID buffer and presents it to decode, which drives the control ROM from id_opcode/id_imm_check.
- Accepts branch/jump redirects from the execute/branch unit; squashes stale fetches.

---
 rtl/fetch_stage_pkg.sv | 35 +++
 rtl/fetch_stage_if_id_buffer.sv | 38 +++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b types for the fetch front end: machine word, opcode field
// and the fetch controller state encoding.
package fetch_stage_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    fetch_idle,
    fetch_req,
    fetch_drop
  } lc3b_fetch_state;

  // BR with nzp=000 never branches, so an all-zero word is a NOP.
  localparam lc3b_word nop_instr = 16'h0000;

endpackage

// File: rtl/fetch_stage_if_id_buffer.sv
// IF/ID pipeline register: one instruction with its pc and pc+2.
// Priority: clear (squash to NOP) over load over consume; otherwise hold.
module fetch_stage_if_id_buffer
  import fetch_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  logic     consume,
  input  lc3b_word load_instr,
  input  lc3b_word load_pc,
  output logic     valid,
  output lc3b_word instr,
  output lc3b_word pc,
  output lc3b_word npc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= nop_instr;
      pc    <= 16'h0000;
      npc   <= 16'h0000;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= nop_instr;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      npc   <= load_pc + 16'd2;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: owns the PC, keeps at most one read outstanding,
// fills the IF/ID buffer and squashes wrong-path fetches on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  output lc3b_word        mem_address,
  output logic            mem_read,
  input  lc3b_word        mem_rdata,
  input  logic            mem_resp,
  input  logic            id_ready,
  output logic            id_valid,
  output lc3b_word        id_instr,
  output lc3b_word        id_pc,
  output lc3b_word        id_npc,
  output lc3b_opcode      id_opcode,
  output logic            id_imm_check,
  input  logic            redirect,
  input  lc3b_word        redirect_pc,
  output lc3b_fetch_state dbg_state
);

  // Handshake: decode consumes id_instr on a cycle where id_valid & id_ready;
  // the buffer may be refilled on any cycle where !id_valid | id_ready.
  // mem_read stays high from request until the mem_resp pulse.

  localparam lc3b_word reset_pc_even = RESET_PC & 16'hFFFE;

  lc3b_fetch_state state;
  lc3b_word        pc;
  lc3b_word        req_addr;
  lc3b_word        target;
  lc3b_word        req_next;
  logic            take;
  logic            buf_free;
  logic            buf_load;
  logic            buf_clear;

  assign target    = redirect_pc & 16'hFFFE;
  assign req_next  = req_addr + 16'd2;
  assign take      = id_valid & id_ready;
  assign buf_free  = ~id_valid | id_ready;

  assign mem_address  = req_addr;
  assign id_opcode    = lc3b_opcode'(id_instr[15:12]);
  assign id_imm_check = id_instr[5];
  assign dbg_state    = state;

  always_comb begin
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    case (state)
      fetch_idle: buf_clear = redirect;
      fetch_req: begin
        buf_clear = redirect;
        buf_load  = ~redirect & mem_read & mem_resp & buf_free;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= fetch_req;
      pc       <= reset_pc_even;
      req_addr <= reset_pc_even;
      mem_read <= 1'b0;
    end else begin
      case (state)
        fetch_idle: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= fetch_req;
            mem_read <= 1'b1;
          end else if (buf_free) begin
            req_addr <= pc;
            state    <= fetch_req;
            mem_read <= 1'b1;
          end
        end
        fetch_req: begin
          // First cycle out of reset: the request is not on the bus yet.
          if (!mem_read) begin
            mem_read <= 1'b1;
            if (redirect) begin
              pc       <= target;
              req_addr <= target;
            end
          end else if (mem_resp) begin
            if (redirect) begin
              pc       <= target;
              req_addr <= target;
            end else if (buf_free) begin
              pc       <= req_next;
              req_addr <= req_next;
            end else begin
              // Response landed on a stalled full buffer: drop it and refetch.
              pc       <= req_addr;
              state    <= fetch_idle;
              mem_read <= 1'b0;
            end
          end else if (redirect) begin
            pc    <= target;
            state <= fetch_drop;
          end
        end
        fetch_drop: begin
          if (redirect) pc <= target;
          if (mem_resp) begin
            req_addr <= redirect ? target : pc;
            state    <= fetch_req;
          end
        end
        default: begin
          state    <= fetch_idle;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

  fetch_stage_if_id_buffer u_if_id (
    .clk        (clk),
    .rst        (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .consume    (take),
    .load_instr (mem_rdata),
    .load_pc    (req_addr),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc         (id_pc),
    .npc        (id_npc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with variable latency, directed
// scenarios, then random redirects/stalls checked against a program-order model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_resp = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_npc;
  logic [3:0]  id_opcode;
  logic        id_imm_check;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int takes = 0;
  int mem_lat = 1;

  // Expected stream entries: {instr, pc, npc}
  logic [47:0] exp_q[$];
  logic [15:0] model_pc = 16'h0000;
  logic [47:0] exp_e;

  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_cur = 16'h0000;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_npc       (id_npc),
    .id_opcode    (id_opcode),
    .id_imm_check (id_imm_check),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0000) return 16'h1261;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- instruction memory model ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      if (reset) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        check("mem_addr_stable", mem_address, mem_cur);
        check("mem_read_held", 16'(mem_read), 16'd1);
        mem_cnt--;
        if (mem_cnt <= 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_word(mem_cur);
          mem_busy  = 1'b0;
        end
      end else if (mem_read) begin
        check("mem_addr_even", 16'(mem_address[0]), 16'd0);
        mem_cur = mem_address;
        mem_cnt = mem_lat;
        if (mem_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_word(mem_cur);
        end else begin
          mem_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  // Decode must see the program in order from the latest redirect target.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_pc = 16'h0000;
    end else if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc & 16'hFFFE;
    end else if (id_valid && id_ready) begin
      exp_e = exp_q.pop_front();
      takes++;
      check("take_instr", id_instr, exp_e[47:32]);
      check("take_pc", id_pc, exp_e[31:16]);
      check("take_npc", id_npc, exp_e[15:0]);
      check("take_opcode", 16'(id_opcode), 16'(exp_e[47:44]));
      check("take_imm", 16'(id_imm_check), 16'(exp_e[37]));
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back({mem_word(model_pc), model_pc, model_pc + 16'd2});
      model_pc = model_pc + 16'd2;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_mem_read", 16'(mem_read), 16'd0);
    check("rst_id_valid", 16'(id_valid), 16'd0);
    check("rst_id_instr", id_instr, 16'h0000);
    check("rst_id_pc", id_pc, 16'h0000);
    check("rst_id_npc", id_npc, 16'h0000);
    check("rst_mem_address", mem_address, 16'h0000);

    // First fetch from RESET_PC, decode stalled.
    drive_slot();
    reset = 1'b0;
    settle();
    check("first_req_read", 16'(mem_read), 16'd1);
    check("first_req_addr", mem_address, 16'h0000);
    n = 0;
    while (!id_valid && n < 20) begin @(negedge clk); n++; end
    check("first_valid", 16'(id_valid), 16'd1);
    check("first_instr", id_instr, 16'h1261);
    check("first_opcode", 16'(id_opcode), 16'h0001);
    check("first_imm", 16'(id_imm_check), 16'd1);
    check("first_pc", id_pc, 16'h0000);
    check("first_npc", id_npc, 16'h0002);
    check("next_req_addr", mem_address, 16'h0002);

    // Stall with full buffer: fetching must stop and outputs hold.
    n = 0;
    while (mem_read && n < 20) begin @(negedge clk); n++; end
    check("stall_goes_idle", 16'(mem_read), 16'd0);
    repeat (5) begin
      @(negedge clk);
      check("stall_no_read", 16'(mem_read), 16'd0);
      check("stall_hold_instr", id_instr, 16'h1261);
      check("stall_hold_pc", id_pc, 16'h0000);
    end
    mem_lat = 3;
    drive_slot();
    id_ready = 1'b1;
    settle();
    check("resume_read", 16'(mem_read), 16'd1);
    check("resume_addr", mem_address, 16'h0002);

    // Redirect while the read of 0x0004 is pending.
    n = 0;
    while (!(mem_read && mem_address == 16'h0004) && n < 40) begin @(negedge clk); n++; end
    check("pending_4", mem_address, 16'h0004);
    drive_slot();
    redirect = 1'b1;
    redirect_pc = 16'h3001;
    drive_slot();
    redirect = 1'b0;
    @(negedge clk);
    check("drop_addr_held", mem_address, 16'h0004);
    check("drop_read_held", 16'(mem_read), 16'd1);
    check("drop_squashed", 16'(id_valid), 16'd0);
    n = 0;
    while (mem_address != 16'h3000 && n < 20) begin @(negedge clk); n++; end
    check("redirect_target_req", mem_address, 16'h3000);
    check("redirect_no_stale", 16'(id_valid), 16'd0);

    // Redirect on the same cycle as mem_resp.
    mem_lat = 1;
    n = 0;
    drive_slot();
    while (!mem_resp && n < 20) begin drive_slot(); n++; end
    check("saw_resp", 16'(mem_resp), 16'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    drive_slot();
    redirect = 1'b0;
    @(negedge clk);
    check("coinc_read", 16'(mem_read), 16'd1);
    check("coinc_addr", mem_address, 16'h0100);
    check("coinc_squash", 16'(id_valid), 16'd0);

    // Address wrap at 0xFFFE.
    drive_slot();
    id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    drive_slot();
    redirect = 1'b0;
    n = 0;
    @(negedge clk);
    while (!id_valid && n < 30) begin @(negedge clk); n++; end
    check("wrap_pc", id_pc, 16'hFFFE);
    check("wrap_npc", id_npc, 16'h0000);
    check("wrap_instr", id_instr, mem_word(16'hFFFE));
    check("wrap_next_addr", mem_address, 16'h0000);
    check("wrap_next_read", 16'(mem_read), 16'd1);

    // Asynchronous reset during an outstanding request.
    drive_slot();
    reset = 1'b1;
    #1;
    check("async_rst_read", 16'(mem_read), 16'd0);
    check("async_rst_valid", 16'(id_valid), 16'd0);
    check("async_rst_addr", mem_address, 16'h0000);
    drive_slot();
    reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (!id_valid && n < 20) begin @(negedge clk); n++; end
    check("restart_pc", id_pc, 16'h0000);
    check("restart_instr", id_instr, 16'h1261);

    // Random stalls, latencies and redirects.
    for (int i = 0; i < 1500; i++) begin
      drive_slot();
      id_ready = ($urandom_range(0, 9) < 7);
      mem_lat  = $urandom_range(0, 3);
      redirect = ($urandom_range(0, 19) == 0);
      if (redirect) redirect_pc = 16'($urandom);
    end
    drive_slot();
    redirect = 1'b0;
    id_ready = 1'b1;
    repeat (20) settle();
    check("progress", 16'(takes > 100), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
